line_clear_ctrl: RTL

//   Sequences the 20x10 playfield frame buffer after a piece locks: scans rows bottom-up,

---
 rtl/line_clear_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: scans the playfield bottom-up after a lock and shifts out full rows.
// Latency: Done is high in cycle 1+ROWS+2F after the accepted Start (F = rows cleared).
// Backpressure: none; Start is ignored while Busy, and the frame buffer must follow Load within one cycle.
//
// Ports:
//   Clk, Reset     clock (rising edge) and asynchronous active-low reset
//   Start          1-cycle pulse from the game FSM: piece locked, begin a scan
//   PixelMap       registered board from the frame buffer, row 0 = top
//   Load           per-row shift enables: Load[k] moves row k-1 into row k, row 0 refills with zeros
//   Busy / Done    scan in progress / 1-cycle scan-complete pulse
//   LinesCleared   rows removed by the most recent scan, held until the next accepted Start
//   TotalLines     saturating count of rows removed since reset
module line_clear_ctrl #(
  parameter int ROWS   = 20,
  parameter int COLS   = 10,
  parameter int CELL_W = 4,
  parameter int TOT_W  = 16
) (
  input  logic                                  Clk,
  input  logic                                  Reset,
  input  logic                                  Start,
  input  logic [ROWS-1:0][COLS-1:0][CELL_W-1:0] PixelMap,
  output logic [ROWS-1:0]                       Load,
  output logic                                  Busy,
  output logic                                  Done,
  output logic [$clog2(ROWS+1)-1:0]             LinesCleared,
  output logic [TOT_W-1:0]                      TotalLines
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int LC_W  = $clog2(ROWS+1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ROW_W-1:0]  r_row;
  logic [LC_W-1:0]   r_lines;
  logic [TOT_W-1:0]  r_total;
  logic              w_row_full;

  // A row is complete only when every cell is occupied (nonzero).
  always_comb begin
    w_row_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (PixelMap[r_row][c] == '0) begin
        w_row_full = 1'b0;
      end
    end
  end

  // Next state and Moore outputs.
  always_comb begin
    w_next = r_state;
    Load   = '0;
    Busy   = (r_state != S_IDLE);
    Done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_row_full) begin
          w_next = S_SHIFT;
        end else if (r_row == '0) begin
          w_next = S_DONE;
        end
      end
      S_SHIFT: begin
        // Everything at or above the full row moves down one; rows below stay put.
        for (int k = 0; k < ROWS; k++) begin
          Load[k] = (ROW_W'(k) <= r_row);
        end
        w_next = S_CHECK;
      end
      S_DONE: begin
        Done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Row pointer and counters. The pointer is not decremented after a SHIFT,
  // so the same row index is re-checked with the row that dropped into it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_row   <= ROW_W'(ROWS-1);
      r_lines <= '0;
      r_total <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_row   <= ROW_W'(ROWS-1);
            r_lines <= '0;
          end
        end
        S_CHECK: begin
          if (!w_row_full && (r_row != '0)) begin
            r_row <= r_row - 1'b1;
          end
        end
        S_SHIFT: begin
          r_lines <= r_lines + 1'b1;
          if (r_total != '1) begin
            r_total <= r_total + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign LinesCleared = r_lines;
  assign TotalLines   = r_total;

endmodule
